// File: rtl/core_pkg.sv
// Shared encodings for the data-side load/store path: RV32I width codes,
// byte-lane select patterns and the access FSM state type.
package core_pkg;
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [3:0] SEL_B    = 4'b0001;
   localparam logic [3:0] SEL_H_LO = 4'b0011;
   localparam logic [3:0] SEL_H_HI = 4'b1100;
   localparam logic [3:0] SEL_W    = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_EXC  = 2'd2,
      ST_DONE = 2'd3
   } lsu_state_e;
endpackage

// File: rtl/lsu_align.sv
// Combinational access decode: legality, alignment, byte-lane select,
// store-data lane replication and load-data lane extraction/extension.
module lsu_align
   import core_pkg::*;
(
   input  logic        we_i,
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic        illegal_o,
   output logic        misaligned_o,
   output logic [3:0]  sel_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o
);
   logic        legal;
   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      legal = 1'b0;
      case (funct3_i)
         F3_B, F3_H, F3_W: legal = 1'b1;
         F3_BU, F3_HU:     legal = ~we_i;
         default:          legal = 1'b0;
      endcase
      illegal_o = ~legal;

      misaligned_o = 1'b0;
      sel_o        = SEL_W;
      wdata_o      = wdata_i;
      case (funct3_i[1:0])
         2'b00: begin
            sel_o   = SEL_B << off_i;
            wdata_o = {4{wdata_i[7:0]}};
         end
         2'b01: begin
            sel_o        = off_i[1] ? SEL_H_HI : SEL_H_LO;
            wdata_o      = {2{wdata_i[15:0]}};
            misaligned_o = legal & off_i[0];
         end
         default: misaligned_o = legal & (off_i != 2'b00);
      endcase
   end

   always_comb begin
      case (off_i)
         2'd0:    byte_v = rdata_i[7:0];
         2'd1:    byte_v = rdata_i[15:8];
         2'd2:    byte_v = rdata_i[23:16];
         default: byte_v = rdata_i[31:24];
      endcase
      half_v = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

      case (funct3_i)
         F3_B:    rdata_o = {{24{byte_v[7]}}, byte_v};
         F3_BU:   rdata_o = {24'd0, byte_v};
         F3_H:    rdata_o = {{16{half_v[15]}}, half_v};
         F3_HU:   rdata_o = {16'd0, half_v};
         default: rdata_o = rdata_i;
      endcase
   end
endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: one Wishbone B4 classic cycle per access, with
// alignment/legality exceptions, bus error, timeout and flush handling.
module load_store_unit
   import core_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        valid_i,
   input  logic        we_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   input  logic        flush_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [31:0] rdata_o,
   output logic        e_ld_addr_mis_o,
   output logic        e_st_addr_mis_o,
   output logic        e_access_fault_o,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_addr_o,
   output logic [31:0] wbm_dat_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i,
   input  logic        wbm_err_i
);
   localparam logic [31:0] TO_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

   lsu_state_e  state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic        cyc_q, cyc_d, we_q, we_d;
   logic [3:0]  sel_q, sel_d;
   logic [31:0] adr_q, adr_d, dat_q, dat_d, rdata_q, rdata_d;
   logic        ld_mis_q, ld_mis_d, st_mis_q, st_mis_d, fault_q, fault_d;

   logic        al_illegal, al_misaligned;
   logic [3:0]  al_sel;
   logic [31:0] al_wdata, al_rdata;
   logic        timeout_hit;

   lsu_align u_align (
      .we_i         (we_i),
      .funct3_i     (funct3_i),
      .off_i        (addr_i[1:0]),
      .wdata_i      (wdata_i),
      .rdata_i      (wbm_dat_i),
      .illegal_o    (al_illegal),
      .misaligned_o (al_misaligned),
      .sel_o        (al_sel),
      .wdata_o      (al_wdata),
      .rdata_o      (al_rdata)
   );

   assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      cyc_d    = cyc_q;
      we_d     = we_q;
      sel_d    = sel_q;
      adr_d    = adr_q;
      dat_d    = dat_q;
      rdata_d  = rdata_q;
      ld_mis_d = ld_mis_q;
      st_mis_d = st_mis_q;
      fault_d  = fault_q;
      case (state_q)
         ST_IDLE: begin
            if (valid_i && !flush_i) begin
               ld_mis_d = al_misaligned & ~we_i;
               st_mis_d = al_misaligned & we_i;
               fault_d  = al_illegal;
               if (al_misaligned || al_illegal) begin
                  state_d = ST_EXC;
               end else begin
                  state_d = ST_REQ;
                  cnt_d   = '0;
                  cyc_d   = 1'b1;
                  we_d    = we_i;
                  sel_d   = al_sel;
                  adr_d   = {addr_i[31:2], 2'b00};
                  dat_d   = we_i ? al_wdata : '0;
               end
            end
         end
         ST_REQ: begin
            // Termination outranks flush: a completed bus cycle must be reported.
            if (wbm_ack_i || wbm_err_i || timeout_hit) begin
               state_d = ST_DONE;
               fault_d = wbm_err_i | (~wbm_ack_i & timeout_hit);
               if (wbm_ack_i && !wbm_err_i && !we_q) rdata_d = al_rdata;
            end else if (flush_i) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
            if (wbm_ack_i || wbm_err_i || timeout_hit || flush_i) begin
               cyc_d = 1'b0;
               we_d  = 1'b0;
               sel_d = '0;
               adr_d = '0;
               dat_d = '0;
            end
         end
         ST_EXC:  state_d = flush_i ? ST_IDLE : ST_DONE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         cyc_q    <= 1'b0;
         we_q     <= 1'b0;
         sel_q    <= '0;
         adr_q    <= '0;
         dat_q    <= '0;
         rdata_q  <= '0;
         ld_mis_q <= 1'b0;
         st_mis_q <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         cyc_q    <= cyc_d;
         we_q     <= we_d;
         sel_q    <= sel_d;
         adr_q    <= adr_d;
         dat_q    <= dat_d;
         rdata_q  <= rdata_d;
         ld_mis_q <= ld_mis_d;
         st_mis_q <= st_mis_d;
         fault_q  <= fault_d;
      end
   end

   assign done_o           = (state_q == ST_DONE) & ~flush_i;
   assign busy_o           = valid_i & ~done_o & ~rst_i;
   assign rdata_o          = rdata_q;
   assign e_ld_addr_mis_o  = ld_mis_q & done_o;
   assign e_st_addr_mis_o  = st_mis_q & done_o;
   assign e_access_fault_o = fault_q & done_o;
   assign wbm_cyc_o        = cyc_q;
   assign wbm_stb_o        = cyc_q;
   assign wbm_we_o         = we_q;
   assign wbm_sel_o        = sel_q;
   assign wbm_addr_o       = adr_q;
   assign wbm_dat_o        = dat_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random
// accesses compared against a byte-arithmetic reference model.
module tb_load_store_unit;
   localparam int TO     = 4;
   localparam int M_ACK  = 0;
   localparam int M_ERR  = 1;
   localparam int M_BOTH = 2;
   localparam int M_NONE = 3;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        valid_i = 1'b0, we_i = 1'b0, flush_i = 1'b0;
   logic [2:0]  funct3_i = 3'd0;
   logic [31:0] addr_i = '0, wdata_i = '0, dat_i = '0;
   logic        ack = 1'b0, err = 1'b0;
   logic        busy_o, done_o, e_ld, e_st, e_af;
   logic        cyc_o, stb_o, wbwe_o;
   logic [3:0]  sel_o;
   logic [31:0] rdata_o, wbaddr_o, wbdat_o;

   int checks = 0;
   int errors = 0;
   logic [31:0] model_rdata;

   // results of the most recent do_access call
   int          r_lat, r_ncyc;
   logic [3:0]  r_sel;
   logic [31:0] r_dat, r_adr, r_rdata;
   logic        r_we, r_ld, r_st, r_flt, r_early, r_busy, r_stb_ok;

   always #5 clk = ~clk;

   load_store_unit #(.TIMEOUT(TO)) dut (
      .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .we_i(we_i), .funct3_i(funct3_i),
      .addr_i(addr_i), .wdata_i(wdata_i), .flush_i(flush_i), .busy_o(busy_o), .done_o(done_o),
      .rdata_o(rdata_o), .e_ld_addr_mis_o(e_ld), .e_st_addr_mis_o(e_st),
      .e_access_fault_o(e_af), .wbm_cyc_o(cyc_o), .wbm_stb_o(stb_o), .wbm_we_o(wbwe_o),
      .wbm_sel_o(sel_o), .wbm_addr_o(wbaddr_o), .wbm_dat_o(wbdat_o), .wbm_dat_i(dat_i),
      .wbm_ack_i(ack), .wbm_err_i(err)
   );

   // Reference: treat an access as nbytes contiguous bytes starting at addr.
   function automatic void ref_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                      input logic [31:0] wdata, input logic [31:0] rd,
                                      output logic legal, output logic mis, output logic [3:0] sel,
                                      output logic [31:0] dat, output logic [31:0] ext);
      int nbytes, off;
      logic [31:0] mask, sel32;
      off    = int'(addr[1:0]);
      nbytes = 1 << int'(f3[1:0]);
      legal  = (f3 <= 3'd2) || (!we && (f3 == 3'd4 || f3 == 3'd5));
      mis    = legal && ((addr % 32'(nbytes)) != 32'd0);
      sel32  = ((32'd1 << nbytes) - 32'd1) << off;
      sel    = sel32[3:0];
      for (int i = 0; i < 4; i++) dat[8*i +: 8] = wdata[8*(i % nbytes) +: 8];
      mask = (nbytes >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*nbytes)) - 32'd1);
      ext  = (rd >> (8*off)) & mask;
      if (!f3[2] && nbytes < 4 && ext[8*nbytes-1]) ext = ext | ~mask;
   endfunction

   // Drives one access starting one time unit after a rising edge; the slave
   // answers after 'waits' REQ cycles according to 'mode'.
   task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rd, input int waits,
                            input int mode, input int flush_cycle, input int maxc);
      int c;
      logic fin;
      r_lat = 0; r_ncyc = 0; r_sel = '0; r_dat = '0; r_adr = '0; r_rdata = '0;
      r_we = 1'b0; r_ld = 1'b0; r_st = 1'b0; r_flt = 1'b0; r_early = 1'b0; r_busy = 1'b0;
      r_stb_ok = 1'b1;
      valid_i = 1'b1; we_i = we; funct3_i = f3; addr_i = addr; wdata_i = wdata;
      c = 1; fin = 1'b0;
      while (!fin) begin
         if (c == flush_cycle) begin
            flush_i = 1'b1;
            valid_i = 1'b0;
         end
         if (cyc_o) begin
            r_ncyc++;
            r_sel = sel_o; r_dat = wbdat_o; r_adr = wbaddr_o; r_we = wbwe_o;
            if (stb_o !== cyc_o) r_stb_ok = 1'b0;
            if (mode != M_NONE && r_ncyc > waits) begin
               ack   = (mode == M_ACK) || (mode == M_BOTH);
               err   = (mode == M_ERR) || (mode == M_BOTH);
               dat_i = rd;
            end
         end
         #1;
         if (cyc_o && r_ncyc == 1) r_busy = busy_o;
         if (done_o) begin
            r_lat = c; r_ld = e_ld; r_st = e_st; r_flt = e_af; r_rdata = rdata_o;
            fin = 1'b1;
         end else begin
            if (e_ld || e_st || e_af) r_early = 1'b1;
            if (c >= maxc) fin = 1'b1;
         end
         if (!fin) begin
            @(posedge clk); #1;
            ack = 1'b0; err = 1'b0; flush_i = 1'b0; dat_i = $urandom;
            c++;
         end
      end
      valid_i = 1'b0; flush_i = 1'b0;
      @(posedge clk); #1;
      ack = 1'b0; err = 1'b0;
      $display("txn we=%0d f3=%0d addr=%h lat=%0d cyc=%0d rdata=%h exc=%b%b%b",
               we, f3, addr, r_lat, r_ncyc, r_rdata, r_ld, r_st, r_flt);
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if ({cyc_o, stb_o, wbwe_o} !== 3'b000) begin errors++; $display("FAIL reset_bus got %b want 000", {cyc_o, stb_o, wbwe_o}); end
      checks++; if ({sel_o, wbaddr_o, wbdat_o} !== '0) begin errors++; $display("FAIL reset_lanes got %h/%h/%h want 0", sel_o, wbaddr_o, wbdat_o); end
      checks++; if (rdata_o !== 32'd0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata_o); end
      checks++; if ({done_o, busy_o, e_ld, e_st, e_af} !== 5'b0) begin errors++; $display("FAIL reset_status got %b want 00000", {done_o, busy_o, e_ld, e_st, e_af}); end
      rst_i = 1'b0;
      model_rdata = '0;
   endtask

   task automatic test_directed();
      do_access(1'b0, 3'b010, 32'h1000, 32'h0, 32'hDEADBEEF, 0, M_ACK, 0, 20);
      checks++; if (r_lat !== 3) begin errors++; $display("FAIL lw_latency got %0d want 3", r_lat); end
      checks++; if (r_sel !== 4'b1111 || r_adr !== 32'h1000 || r_we !== 1'b0) begin errors++; $display("FAIL lw_bus got sel=%b adr=%h we=%b want 1111/00001000/0", r_sel, r_adr, r_we); end
      checks++; if (r_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata got %h want deadbeef", r_rdata); end
      checks++; if (r_busy !== 1'b1 || r_stb_ok !== 1'b1) begin errors++; $display("FAIL lw_busy_stb got %b%b want 11", r_busy, r_stb_ok); end
      checks++; if ({done_o, rdata_o} !== {1'b0, 32'hDEADBEEF}) begin errors++; $display("FAIL lw_hold got done=%b rdata=%h want 0/deadbeef", done_o, rdata_o); end

      do_access(1'b0, 3'b000, 32'h1003, 32'h0, 32'h80FFFFFF, 0, M_ACK, 0, 20);
      checks++; if (r_sel !== 4'b1000 || r_rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL lb got sel=%b rdata=%h want 1000/ffffff80", r_sel, r_rdata); end
      do_access(1'b0, 3'b100, 32'h1003, 32'h0, 32'h80FFFFFF, 0, M_ACK, 0, 20);
      checks++; if (r_rdata !== 32'h00000080) begin errors++; $display("FAIL lbu got %h want 00000080", r_rdata); end

      do_access(1'b1, 3'b001, 32'h2002, 32'h1234ABCD, 32'h0, 2, M_ACK, 0, 20);
      checks++; if (r_we !== 1'b1 || r_sel !== 4'b1100 || r_dat !== 32'hABCDABCD) begin errors++; $display("FAIL sh_bus got we=%b sel=%b dat=%h want 1/1100/abcdabcd", r_we, r_sel, r_dat); end
      checks++; if (r_lat !== 5 || r_ncyc !== 3) begin errors++; $display("FAIL sh_latency got %0d/%0d want 5/3", r_lat, r_ncyc); end
      checks++; if (r_rdata !== 32'h00000080 || {r_ld, r_st, r_flt} !== 3'b000) begin errors++; $display("FAIL sh_side got rdata=%h exc=%b%b%b want 00000080/000", r_rdata, r_ld, r_st, r_flt); end
      model_rdata = 32'h00000080;
   endtask

   task automatic test_misaligned();
      do_access(1'b0, 3'b010, 32'h1002, 32'h0, 32'h0, 0, M_ACK, 0, 20);
      checks++; if (r_ncyc !== 0 || r_lat !== 3) begin errors++; $display("FAIL lw_mis_timing got cyc=%0d lat=%0d want 0/3", r_ncyc, r_lat); end
      checks++; if ({r_ld, r_st, r_flt, r_early} !== 4'b1000) begin errors++; $display("FAIL lw_mis_exc got %b want 1000", {r_ld, r_st, r_flt, r_early}); end
      do_access(1'b1, 3'b001, 32'h2001, 32'h55, 32'h0, 0, M_ACK, 0, 20);
      checks++; if ({r_ld, r_st, r_flt} !== 3'b010 || r_ncyc !== 0) begin errors++; $display("FAIL sh_mis got %b cyc=%0d want 010/0", {r_ld, r_st, r_flt}, r_ncyc); end
      do_access(1'b1, 3'b100, 32'h2000, 32'h55, 32'h0, 0, M_ACK, 0, 20);
      checks++; if ({r_ld, r_st, r_flt} !== 3'b001 || r_ncyc !== 0) begin errors++; $display("FAIL st_illegal got %b cyc=%0d want 001/0", {r_ld, r_st, r_flt}, r_ncyc); end
      do_access(1'b0, 3'b011, 32'h2000, 32'h0, 32'h0, 0, M_ACK, 0, 20);
      checks++; if ({r_ld, r_st, r_flt} !== 3'b001) begin errors++; $display("FAIL ld_illegal got %b want 001", {r_ld, r_st, r_flt}); end
      checks++; if (rdata_o !== model_rdata) begin errors++; $display("FAIL exc_rdata got %h want %h", rdata_o, model_rdata); end
   endtask

   task automatic test_bus_fault();
      do_access(1'b0, 3'b010, 32'h4000, 32'h0, 32'h0, 0, M_NONE, 0, 20);
      checks++; if (r_ncyc !== TO || r_lat !== TO + 2) begin errors++; $display("FAIL timeout_timing got cyc=%0d lat=%0d want %0d/%0d", r_ncyc, r_lat, TO, TO + 2); end
      checks++; if ({r_ld, r_st, r_flt} !== 3'b001) begin errors++; $display("FAIL timeout_fault got %b want 001", {r_ld, r_st, r_flt}); end
      do_access(1'b0, 3'b010, 32'h4000, 32'h0, 32'h11223344, 0, M_ERR, 0, 20);
      checks++; if ({r_ld, r_st, r_flt} !== 3'b001 || r_lat !== 3) begin errors++; $display("FAIL err_fault got %b lat=%0d want 001/3", {r_ld, r_st, r_flt}, r_lat); end
      do_access(1'b0, 3'b010, 32'h4000, 32'h0, 32'h55667788, 1, M_BOTH, 0, 20);
      checks++; if (r_flt !== 1'b1 || r_rdata !== model_rdata) begin errors++; $display("FAIL ack_err got flt=%b rdata=%h want 1/%h", r_flt, r_rdata, model_rdata); end
      do_access(1'b1, 3'b010, 32'h4004, 32'hCAFEF00D, 32'h0, 0, M_ERR, 0, 20);
      checks++; if ({r_ld, r_st, r_flt} !== 3'b001 || r_dat !== 32'hCAFEF00D) begin errors++; $display("FAIL st_err got %b dat=%h want 001/cafef00d", {r_ld, r_st, r_flt}, r_dat); end
   endtask

   task automatic test_flush();
      do_access(1'b0, 3'b010, 32'h5000, 32'h0, 32'h0, 0, M_NONE, 3, 8);
      checks++; if (r_ncyc !== 2 || r_lat !== 0 || r_early !== 1'b0) begin errors++; $display("FAIL flush_req got cyc=%0d lat=%0d early=%b want 2/0/0", r_ncyc, r_lat, r_early); end
      do_access(1'b0, 3'b010, 32'h5001, 32'h0, 32'h0, 0, M_ACK, 2, 6);
      checks++; if (r_lat !== 0 || r_early !== 1'b0) begin errors++; $display("FAIL flush_exc got lat=%0d early=%b want 0/0", r_lat, r_early); end
      do_access(1'b1, 3'b010, 32'h5004, 32'h9, 32'h0, 0, M_ACK, 3, 6);
      checks++; if (r_lat !== 0 || r_ncyc !== 1 || r_early !== 1'b0) begin errors++; $display("FAIL flush_done got lat=%0d cyc=%0d early=%b want 0/1/0", r_lat, r_ncyc, r_early); end
      do_access(1'b0, 3'b101, 32'h5006, 32'h0, 32'h8001_7FFF, 0, M_ACK, 0, 20);
      checks++; if (r_lat !== 3 || r_rdata !== 32'h00008001) begin errors++; $display("FAIL after_flush got lat=%0d rdata=%h want 3/00008001", r_lat, r_rdata); end
      model_rdata = 32'h00008001;
   endtask

   task automatic test_reset_mid();
      valid_i = 1'b1; we_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h3000; wdata_i = 32'h77;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++; if (cyc_o !== 1'b1) begin errors++; $display("FAIL rst_mid_pre got cyc=%b want 1", cyc_o); end
      rst_i = 1'b1;
      #1;
      checks++; if ({cyc_o, stb_o, wbwe_o, sel_o, wbaddr_o, wbdat_o} !== '0) begin errors++; $display("FAIL rst_mid_bus got cyc=%b sel=%b adr=%h want 0", cyc_o, sel_o, wbaddr_o); end
      checks++; if ({done_o, busy_o, e_ld, e_st, e_af} !== 5'b0 || rdata_o !== 32'd0) begin errors++; $display("FAIL rst_mid_status got %b rdata=%h want 0", {done_o, busy_o, e_ld, e_st, e_af}, rdata_o); end
      valid_i = 1'b0;
      model_rdata = '0;
      @(posedge clk); #1;
      rst_i = 1'b0;
   endtask

   task automatic test_random();
      logic we, legal, mis, exc;
      logic [2:0] f3;
      logic [31:0] addr, wdata, rd, dat, ext;
      logic [3:0] sel;
      int waits, mode, r, exp_ncyc, exp_lat;
      for (int n = 0; n < 60; n++) begin
         we = 1'($urandom_range(0, 1)); f3 = 3'($urandom_range(0, 7));
         addr = $urandom; wdata = $urandom; rd = $urandom;
         waits = int'($urandom_range(0, 2));
         r = int'($urandom_range(0, 9));
         mode = (r <= 6) ? M_ACK : (r == 7) ? M_ERR : (r == 8) ? M_BOTH : M_NONE;
         ref_access(we, f3, addr, wdata, rd, legal, mis, sel, dat, ext);
         exc = !legal || mis;
         exp_ncyc = exc ? 0 : (mode == M_NONE) ? TO : waits + 1;
         exp_lat  = exc ? 3 : exp_ncyc + 2;
         if (!exc && mode == M_ACK && !we) model_rdata = ext;
         do_access(we, f3, addr, wdata, rd, waits, mode, 0, 20);
         checks++; if (r_lat !== exp_lat || r_ncyc !== exp_ncyc) begin errors++; $display("FAIL rnd%0d_timing got lat=%0d cyc=%0d want %0d/%0d", n, r_lat, r_ncyc, exp_lat, exp_ncyc); end
         checks++; if ({r_ld, r_st, r_flt, r_early} !== {legal && mis && !we, legal && mis && we, !legal || (!exc && mode != M_ACK), 1'b0})
            begin errors++; $display("FAIL rnd%0d_exc got %b%b%b early=%b legal=%b mis=%b mode=%0d", n, r_ld, r_st, r_flt, r_early, legal, mis, mode); end
         checks++; if (r_rdata !== model_rdata) begin errors++; $display("FAIL rnd%0d_rdata got %h want %h", n, r_rdata, model_rdata); end
         if (!exc) begin
            checks++; if (r_sel !== sel || r_adr !== {addr[31:2], 2'b00} || r_we !== we)
               begin errors++; $display("FAIL rnd%0d_bus got sel=%b adr=%h we=%b want %b/%h/%b", n, r_sel, r_adr, r_we, sel, {addr[31:2], 2'b00}, we); end
            if (we) begin
               checks++; if (r_dat !== dat) begin errors++; $display("FAIL rnd%0d_wdat got %h want %h", n, r_dat, dat); end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_misaligned();
      test_bus_fault();
      test_flush();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
